// File: rtl/edsac_order_pkg.sv
// Shared EDSAC order definitions: function codes, control-line bit positions
// and the sequencer state encoding.
package edsac_order_pkg;

    localparam logic [4:0] FN_P     = 5'd0;
    localparam logic [4:0] FN_Q     = 5'd1;
    localparam logic [4:0] FN_W     = 5'd2;
    localparam logic [4:0] FN_E     = 5'd3;
    localparam logic [4:0] FN_R     = 5'd4;
    localparam logic [4:0] FN_T     = 5'd5;
    localparam logic [4:0] FN_Y     = 5'd6;
    localparam logic [4:0] FN_U     = 5'd7;
    localparam logic [4:0] FN_I     = 5'd8;
    localparam logic [4:0] FN_O     = 5'd9;
    localparam logic [4:0] FN_J     = 5'd10;
    localparam logic [4:0] FN_PI    = 5'd11;
    localparam logic [4:0] FN_S     = 5'd12;
    localparam logic [4:0] FN_Z     = 5'd13;
    localparam logic [4:0] FN_K     = 5'd14;
    localparam logic [4:0] FN_ERASE = 5'd15;
    localparam logic [4:0] FN_BLANK = 5'd16;
    localparam logic [4:0] FN_F     = 5'd17;
    localparam logic [4:0] FN_THETA = 5'd18;
    localparam logic [4:0] FN_D     = 5'd19;
    localparam logic [4:0] FN_PHI   = 5'd20;
    localparam logic [4:0] FN_H     = 5'd21;
    localparam logic [4:0] FN_N     = 5'd22;
    localparam logic [4:0] FN_M     = 5'd23;
    localparam logic [4:0] FN_DELTA = 5'd24;
    localparam logic [4:0] FN_L     = 5'd25;
    localparam logic [4:0] FN_X     = 5'd26;
    localparam logic [4:0] FN_G     = 5'd27;
    localparam logic [4:0] FN_A     = 5'd28;
    localparam logic [4:0] FN_B     = 5'd29;
    localparam logic [4:0] FN_C     = 5'd30;
    localparam logic [4:0] FN_V     = 5'd31;

    localparam int C1_IDX  = 0;
    localparam int C2_IDX  = 1;
    localparam int C3_IDX  = 2;
    localparam int C4_IDX  = 3;
    localparam int C5_IDX  = 4;
    localparam int C6_IDX  = 5;
    localparam int C7_IDX  = 6;
    localparam int C8_IDX  = 7;
    localparam int C9_IDX  = 8;
    localparam int C10_IDX = 9;
    localparam int C11_IDX = 10;
    localparam int C12_IDX = 11;
    localparam int C13_IDX = 12;
    localparam int C14_IDX = 13;
    localparam int C15_IDX = 14;
    localparam int C16_IDX = 15;
    localparam int C17_IDX = 16;
    localparam int C18_IDX = 17;
    localparam int C19_IDX = 18;
    localparam int C20_IDX = 19;
    localparam int C21_IDX = 20;
    localparam int C22_IDX = 21;
    localparam int C23_IDX = 22;
    localparam int C24_IDX = 23;
    localparam int C25_IDX = 24;
    localparam int C26_IDX = 25;
    localparam int C27_IDX = 26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE,
        ST_HALT
    } seq_state_e;

endpackage

// File: rtl/order_decode.sv
// Combinational EDSAC order decoder: function code to c1-c27 lines plus stop flag.
// ORDER_SEQ_EXT_ORDERS_EN turns J and P into no-op orders instead of stops.
module order_decode
    import edsac_order_pkg::*;
(
    input  logic [4:0]  fn_i,
    output logic [26:0] ctrl_o,
    output logic        stop_o
);

    always_comb begin
        ctrl_o = '0;
        stop_o = 1'b0;
        case (fn_i)
            FN_A: begin ctrl_o[C1_IDX] = 1'b1; ctrl_o[C2_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1; end
            FN_S: begin ctrl_o[C1_IDX] = 1'b1; ctrl_o[C3_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1; end
            FN_C: begin
                ctrl_o[C1_IDX]  = 1'b1; ctrl_o[C4_IDX]  = 1'b1;
                ctrl_o[C24_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1;
            end
            FN_V: begin
                ctrl_o[C1_IDX]  = 1'b1; ctrl_o[C5_IDX]  = 1'b1;
                ctrl_o[C14_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1;
            end
            FN_N: begin
                ctrl_o[C1_IDX]  = 1'b1; ctrl_o[C5_IDX]  = 1'b1;
                ctrl_o[C11_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1;
            end
            FN_R: begin ctrl_o[C6_IDX] = 1'b1; ctrl_o[C7_IDX] = 1'b1; end
            FN_L: begin ctrl_o[C6_IDX] = 1'b1; ctrl_o[C8_IDX] = 1'b1; end
            FN_X: begin ctrl_o[C9_IDX] = 1'b1; ctrl_o[C12_IDX] = 1'b1; end
            FN_Y: begin ctrl_o[C9_IDX] = 1'b1; ctrl_o[C13_IDX] = 1'b1; end
            FN_G: ctrl_o[C10_IDX] = 1'b1;
            FN_I: begin ctrl_o[C16_IDX] = 1'b1; ctrl_o[C17_IDX] = 1'b1; ctrl_o[C27_IDX] = 1'b1; end
            FN_T: begin ctrl_o[C17_IDX] = 1'b1; ctrl_o[C19_IDX] = 1'b1; ctrl_o[C20_IDX] = 1'b1; end
            FN_U: begin ctrl_o[C17_IDX] = 1'b1; ctrl_o[C19_IDX] = 1'b1; end
            FN_F: ctrl_o[C17_IDX] = 1'b1;
            FN_H: begin ctrl_o[C18_IDX] = 1'b1; ctrl_o[C24_IDX] = 1'b1; ctrl_o[C26_IDX] = 1'b1; end
            FN_O: begin ctrl_o[C21_IDX] = 1'b1; ctrl_o[C27_IDX] = 1'b1; end
            FN_E: ctrl_o[C25_IDX] = 1'b1;
`ifdef ORDER_SEQ_EXT_ORDERS_EN
            FN_J, FN_P: ;
`else
            FN_J, FN_P: stop_o = 1'b1;
`endif
            FN_PI, FN_K, FN_ERASE, FN_BLANK, FN_THETA, FN_D, FN_PHI,
            FN_M, FN_DELTA, FN_B, FN_Z, FN_Q, FN_W: stop_o = 1'b1;
            default: ;
        endcase
        if (stop_o) ctrl_o[C22_IDX] = 1'b1;
        // c15 and c23 are unassigned lines in this machine and are tied low
        ctrl_o[C15_IDX] = 1'b0;
        ctrl_o[C23_IDX] = 1'b0;
    end

endmodule

// File: rtl/order_sequencer.sv
// Handshaked EDSAC order sequencer: decode, hold control lines for N minor cycles,
// then complete or halt. ORDER_SEQ_EXT_ORDERS_EN (in order_decode) makes J/P no-ops.
module order_sequencer
    import edsac_order_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int STD_CYCLES = 1,
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic [4:0]  order_fn,
    input  logic [9:0]  order_addr,
    input  logic        order_long,
    input  logic        mc_tick,
    input  logic        starter,
    output logic [26:0] ctrl,
    output logic        busy,
    output logic        done,
    output logic        halted
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_d;
    logic [26:0]       ctrl_q;
    logic              busy_q, done_q, halted_q;
    logic [26:0]       dec_ctrl;
    logic              dec_stop;

    // Shift length: 1 + position of the lowest set bit, 12 when the field is empty
    function automatic int shift_len(input logic [10:0] field);
        int n;
        n = 12;
        for (int i = 10; i >= 0; i--) begin
            if (field[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_len(input int n);
        if (n > CNT_MAX) return CNT_MAX[CNT_W-1:0];
        if (n < 1)       return {{(CNT_W-1){1'b0}}, 1'b1};
        return n[CNT_W-1:0];
    endfunction

    order_decode u_decode (
        .fn_i   (order_fn),
        .ctrl_o (dec_ctrl),
        .stop_o (dec_stop)
    );

    always_comb begin
        case (order_fn)
            FN_V, FN_N: len_d = sat_len(MUL_CYCLES);
            FN_R, FN_L: len_d = sat_len(shift_len({order_addr, order_long}));
            default:    len_d = sat_len(STD_CYCLES);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (order_valid) begin
                        ctrl_q <= dec_ctrl;
                        cnt_q  <= len_d;
                        if (dec_stop) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (mc_tick) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ctrl_q  <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                ST_HALT: begin
                    if (starter) begin
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b0;
                        ctrl_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign order_ready = (state_q == ST_IDLE);
    assign ctrl        = ctrl_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_order_sequencer.sv
// Directed + randomized bench for order_sequencer against a table-driven order model.
module tb_order_sequencer;

    localparam int CNT_W = 5;
    localparam int STD   = 1;
    localparam int MUL   = 4;

    logic        clk = 1'b0;
    logic        rst, order_valid, order_ready, order_long, mc_tick, starter;
    logic [4:0]  order_fn;
    logic [9:0]  order_addr;
    logic [26:0] ctrl;
    logic        busy, done, halted;

    int n_pass  = 0;
    int n_total = 0;

    order_sequencer #(.CNT_W(CNT_W), .STD_CYCLES(STD), .MUL_CYCLES(MUL)) dut (
        .clk         (clk),
        .rst         (rst),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_fn    (order_fn),
        .order_addr  (order_addr),
        .order_long  (order_long),
        .mc_tick     (mc_tick),
        .starter     (starter),
        .ctrl        (ctrl),
        .busy        (busy),
        .done        (done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] b(input int n);
        return 32'd1 << n;
    endfunction

    // Set of function codes driving control line ck (group table of the order coder)
    function automatic logic [31:0] line_mask(input int k);
        logic [31:0] m;
        case (k)
            1:  m = b(28) | b(12) | b(30) | b(31) | b(22);
            2:  m = b(28);
            3:  m = b(12);
            4:  m = b(30);
            5:  m = b(31) | b(22);
            6:  m = b(4) | b(25);
            7:  m = b(4);
            8:  m = b(25);
            9:  m = b(26) | b(6);
            10: m = b(27);
            11: m = b(22);
            12: m = b(26);
            13: m = b(6);
            14: m = b(31);
            16: m = b(8);
            17: m = b(5) | b(7) | b(8) | b(17);
            18: m = b(21);
            19: m = b(5) | b(7);
            20: m = b(5);
            21: m = b(9);
            22: begin
                m = b(11) | b(14) | b(15) | b(16) | b(18) | b(19) | b(20) | b(23)
                  | b(24) | b(29) | b(13) | b(1) | b(2);
`ifndef ORDER_SEQ_EXT_ORDERS_EN
                m = m | b(10) | b(0);
`endif
            end
            24: m = b(21) | b(30);
            25: m = b(3);
            26: m = b(21) | b(28) | b(12) | b(30) | b(31) | b(22);
            27: m = b(8) | b(9);
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    function automatic logic [26:0] model_ctrl(input int fn);
        logic [26:0] r;
        logic [31:0] m;
        r = '0;
        for (int k = 1; k <= 27; k++) begin
            m = line_mask(k);
            r[k-1] = m[fn];
        end
        return r;
    endfunction

    function automatic bit model_stop(input int fn);
        logic [31:0] m;
        m = line_mask(22);
        return m[fn];
    endfunction

    function automatic int model_len(input int fn, input int addr, input bit lng);
        int n, v;
        if (fn == 31 || fn == 22) n = MUL;
        else if (fn == 4 || fn == 25) begin
            v = addr * 2 + int'(lng);
            if (v == 0) n = 12;
            else begin
                n = 1;
                while (v % 2 == 0) begin v = v / 2; n++; end
            end
        end else n = STD;
        if (n > (2 ** CNT_W) - 1) n = (2 ** CNT_W) - 1;
        return n;
    endfunction

    task automatic accept(input int fn, input int addr, input bit lng, input string tag);
        int waited;
        waited = 0;
        while (order_ready !== 1'b1 && waited < 20) begin step(); waited++; end
        chk({tag, " ready"}, order_ready, 1);
        order_fn    = fn[4:0];
        order_addr  = addr[9:0];
        order_long  = lng;
        order_valid = 1'b1;
        mc_tick     = 1'($urandom_range(0, 1));
        step();
        order_valid = 1'b0;
        mc_tick     = 1'b0;
    endtask

    task automatic run_order(input int fn, input int addr, input bit lng,
                             input int gmin, input int gmax, input string tag);
        logic [26:0] ec;
        int len;
        bit stop;
        ec   = model_ctrl(fn);
        len  = model_len(fn, addr, lng);
        stop = model_stop(fn);
        accept(fn, addr, lng, tag);
        chk({tag, " ctrl"}, ctrl, ec);
        chk({tag, " busy"}, busy, stop ? 0 : 1);
        chk({tag, " halted"}, halted, stop ? 1 : 0);
        chk({tag, " ready_low"}, order_ready, 0);
        if (stop) begin
            repeat (10) begin mc_tick = 1'b1; step(); mc_tick = 1'b0; step(); end
            chk({tag, " halt_ctrl"}, ctrl, ec);
            chk({tag, " halt_hold"}, halted, 1);
            chk({tag, " halt_done"}, done, 0);
            starter = 1'b1; step(); starter = 1'b0;
            chk({tag, " start_halted"}, halted, 0);
            chk({tag, " start_ctrl"}, ctrl, 0);
            chk({tag, " start_ready"}, order_ready, 1);
        end else begin
            for (int t = 1; t <= len; t++) begin
                repeat ($urandom_range(gmax, gmin)) step();
                chk({tag, " busy_pre"}, busy, 1);
                mc_tick = 1'b1; step(); mc_tick = 1'b0;
                if (t < len) begin
                    chk({tag, " done_early"}, done, 0);
                    chk({tag, " ctrl_hold"}, ctrl, ec);
                end else begin
                    chk({tag, " done"}, done, 1);
                    chk({tag, " ctrl_clr"}, ctrl, 0);
                    chk({tag, " busy_end"}, busy, 0);
                end
            end
            step();
            chk({tag, " done_pulse"}, done, 0);
            chk({tag, " ready_back"}, order_ready, 1);
        end
    endtask

    initial begin
        rst = 1'b1; order_valid = 1'b0; mc_tick = 1'b0; starter = 1'b0;
        order_fn = '0; order_addr = '0; order_long = 1'b0;
        step(); step();
        chk("rst ctrl", ctrl, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst halted", halted, 0);
        chk("rst ready", order_ready, 1);
        rst = 1'b0;

        starter = 1'b1; step(); starter = 1'b0;
        chk("idle_starter ready", order_ready, 1);
        chk("idle_starter halted", halted, 0);

        run_order(28, 0, 1'b0, 0, 1, "A");
        run_order(31, 0, 1'b0, 2, 2, "V");
        run_order(4, 0, 1'b0, 0, 0, "R0");
        run_order(4, 8, 1'b0, 0, 1, "R8");
        run_order(25, 0, 1'b1, 0, 1, "L1");
        run_order(13, 0, 1'b0, 0, 0, "Z");
        run_order(10, 0, 1'b0, 0, 1, "J");
        run_order(0, 5, 1'b1, 0, 1, "P");

        // Reset in the middle of a multiply
        accept(31, 0, 1'b0, "Vrst");
        repeat (2) begin mc_tick = 1'b1; step(); mc_tick = 1'b0; step(); end
        chk("Vrst busy_mid", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("Vrst busy", busy, 0);
        chk("Vrst done", done, 0);
        chk("Vrst ctrl", ctrl, 0);
        chk("Vrst halted", halted, 0);
        chk("Vrst ready", order_ready, 1);
        step();
        chk("Vrst no_done", done, 0);
        run_order(28, 0, 1'b0, 0, 1, "A_after_rst");

        repeat (40) begin
            run_order(int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)),
                      1'($urandom_range(0, 1)), 0, 2, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/order_sequencer.md
# order_sequencer

Registered, handshaked successor to the EDSAC order coder. It accepts one order per transaction from the control section: 5-bit teleprinter function code, 10-bit address and long bit. It decodes the order into the c1–c27 control-line bus and holds that bus for a per-order number of minor cycles. It then signals completion, or halts on stop and unassigned orders until the starter is pressed. It sits between the order tank fetch logic and the arithmetic/store control gates.

## Interface
Parameters:
- `CNT_W`, 5: width of the minor-cycle execution counter.
- `STD_CYCLES`, 1: minor cycles for all single-length non-shift, non-multiply orders.
- `MUL_CYCLES`, 4: minor cycles for V and N orders.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `order_valid`  in  1  order fields valid
- `order_ready`  out  1  sequencer accepts an order this cycle
- `order_fn`  in  5  EDSAC function code (P=0, Q=1, W=2, E=3, R=4, T=5, Y=6, U=7, I=8, O=9, J=10, π=11, S=12, Z=13, K=14, erase=15, blank=16, F=17, θ=18, D=19, φ=20, H=21, N=22, M=23, Δ=24, L=25, X=26, G=27, A=28, B=29, C=30, V=31)
- `order_addr`  in  10  address field
- `order_long`  in  1  long-order bit
- `mc_tick`  in  1  one-cycle minor-cycle strobe
- `starter`  in  1  starter pulse, leaves HALT
- `ctrl`  out  27  control lines; bit k-1 = ck; bits 14 and 22 (c15, c23) are always 0
- `busy`  out  1  order executing
- `done`  out  1  one-cycle pulse at order completion
- `halted`  out  1  in HALT state

## Operation
- States are IDLE, EXEC, DONE and HALT. Reset enters IDLE with `ctrl`=0, `busy`=0, `done`=0, `halted`=0 and counter 0.
- **IDLE:**
  - `order_ready`=1.
  - On `order_valid` the fields are captured and the combinational decode result is registered into `ctrl`.
  - Next state is EXEC, or HALT for stop-class orders.
  - The counter loads the cycle length.
- **Decode groups:**
  - c1 = A, S, C, V, N
  - c5 = V, N
  - c6 = R, L
  - c9 = X, Y
  - c17 = T, U, I, F
  - c17a = F, I, T, U
  - c19 = T, U
  - c24 = H, C
  - c26 = H, A, S, C, V, N
  - c27 = I, O
  - Single lines: c2=A, c3=S, c4=C, c7=R, c8=L, c10=G, c11=N, c12=X, c13=Y, c14=V, c16=I, c18=H, c20=T, c21=O, c25=E.
  - c22 (stop) = π, K, erase, blank, θ, D, φ, M, Δ, B, Z, Q, W, plus J and P unless the extended set is enabled (see Configuration).
- **Cycle length:**
  - V and N: `MUL_CYCLES`.
  - R and L: 1 + index of the least-significant 1 in the 11-bit field {`order_addr`,`order_long`}, with `order_long` as bit 0. An all-zero field gives 12.
  - All other orders: `STD_CYCLES`.
  - Lengths saturate at 2^CNT_W−1.
- **EXEC:**
  - `busy`=1 and `ctrl` is held.
  - Each `mc_tick` decrements the counter. The tick that takes it from 1 to 0 moves to DONE.
- **DONE:** lasts one cycle. `done`=1, `ctrl` clears to 0, then return to IDLE.
- **HALT:**
  - `halted`=1, `ctrl` holds c22 only, `order_ready`=0.
  - `starter` moves to IDLE with `ctrl`=0. `mc_tick` is ignored.
- **IDLE with starter:** `starter` has no effect.
- **Simultaneous events:** `rst` dominates every other input in all states.

## Timing
- Accept at edge N: `ctrl` is valid after edge N. `busy` is high from edge N.
- With L minor cycles, `done` is high for the cycle following the L-th `mc_tick` edge.
- An `mc_tick` coincident with acceptance is not counted.
- Earliest next accept is the cycle after DONE, so back-to-back orders have 2 clk of overhead beyond the ticks.
- `order_ready` is a registered-state function with no combinational path from `order_valid`.
- Reset mid-EXEC: the next cycle is IDLE, with no `done` pulse.

## Configuration
- Macro: `ORDER_SEQ_EXT_ORDERS_EN`.
- **Defined:** J and P are extended no-op orders. `ctrl`=0 for `STD_CYCLES`, then a normal `done`. No halt.
- **Undefined:** J and P assert c22 and enter HALT, the original EDSAC behaviour.

## Structure
- **Shared package `edsac_order_pkg`:**
  - 5-bit function-code localparams (`FN_A`=28, …).
  - Control-line index constants (`C1_IDX`…`C27_IDX`).
  - State enum.
- **Sub-module `order_decode`:** purely combinational, fn code to 27-bit `ctrl` plus a stop flag. It is instanced once.
- The top module holds the FSM, counter and shift-length priority encoder.

## Test plan
- A (fn=28), `STD_CYCLES`=1: accept → `ctrl`=c1|c2|c26 held; after 1 tick `done` pulses, then `ctrl`=0.
- V (fn=31) with 4 ticks spaced 3 clk apart → `busy` high throughout, `done` exactly 1 clk after the 4th tick edge, `ctrl` has c1, c5, c14, c26.
- R (fn=4), addr=0, long=0 → 12 ticks needed. R with addr=0b0000001000, long=0 → 5 ticks.
- Z (fn=13) → `halted`=1, `ctrl`=c22 only, `order_ready`=0; 10 ticks give no change; `starter` → IDLE, `ctrl`=0.
- J (fn=10), both macro settings: defined → `done` after 1 tick, no halt; undefined → HALT.
- `rst` asserted after 2 of 4 V ticks → IDLE next cycle, no `done`, all outputs 0; the next A order runs normally.
